// File: rtl/cernbe_bus_master.sv
// 64-bit command initiator for CERN-BE/VME-style register slaves.
// Each request becomes two 32-bit bus cycles: upper word, then lower word.
module cernbe_bus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-4:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-3:0] VMEAddr,
    output logic [31:0]           VMEWrData,
    input  logic [31:0]           VMERdData,
    output logic                  VMERdMem,
    output logic                  VMEWrMem,
    input  logic                  VMERdDone,
    input  logic                  VMEWrDone
);

    localparam logic [15:0] TO = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, STB_HI, WAIT_HI, STB_LO, WAIT_LO, RESP
    } state_t;

    state_t                state, state_n;
    logic                  we_q;
    logic [ADDR_WIDTH-4:0] addr_q;
    logic [63:0]           wdata_q;
    logic [15:0]           cnt;

    logic accept, in_hi, in_lo, done, expired;
    logic we_n, stb_d, rd_mem_d, wr_mem_d, ready_d, rsp_valid_d;

    assign accept  = req_valid && req_ready;
    assign in_hi   = (state == STB_HI) || (state == WAIT_HI);
    assign in_lo   = (state == STB_LO) || (state == WAIT_LO);
    assign done    = (in_hi || in_lo) && (we_q ? VMEWrDone : VMERdDone);
    assign expired = (cnt == TO);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = STB_HI;
            end
            STB_HI, WAIT_HI: begin
                if (done)         state_n = STB_LO;
                else if (expired) state_n = RESP;
                else              state_n = WAIT_HI;
            end
            STB_LO, WAIT_LO: begin
                if (done || expired) state_n = RESP;
                else                 state_n = WAIT_LO;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs are computed from the next state and registered below.
    always_comb begin
        we_n        = accept ? req_we : we_q;
        stb_d       = (state_n == STB_HI) || (state_n == STB_LO);
        rd_mem_d    = stb_d && !we_n;
        wr_mem_d    = stb_d && we_n;
        ready_d     = (state_n == IDLE);
        rsp_valid_d = (state_n == RESP);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            VMEAddr   <= '0;
            VMEWrData <= '0;
            VMERdMem  <= 1'b0;
            VMEWrMem  <= 1'b0;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            VMERdMem  <= rd_mem_d;
            VMEWrMem  <= wr_mem_d;
            if (accept) begin
                we_q      <= req_we;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
                VMEAddr   <= {req_addr, 1'b0};
                VMEWrData <= req_wdata[63:32];
                cnt       <= 16'd1;
            end else if (done && in_hi) begin
                if (!we_q) rsp_rdata[63:32] <= VMERdData;
                VMEAddr   <= {addr_q, 1'b1};
                VMEWrData <= wdata_q[31:0];
                cnt       <= 16'd1;
            end else if (done && in_lo) begin
                if (!we_q) rsp_rdata[31:0] <= VMERdData;
            end else if (in_hi || in_lo) begin
                if (expired) rsp_err <= 1'b1;
                else         cnt     <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cernbe_bus_master.sv
// Testbench for cernbe_bus_master: vector table, hand sequences and
// randomized transactions against a transaction-level reference model.
module tb_cernbe_bus_master;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req_valid, req_ready, req_we;
    logic [4:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic [5:0]  VMEAddr;
    logic [31:0] VMEWrData, VMERdData;
    logic        VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    cernbe_bus_master #(.ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdData(VMERdData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
        .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
    );

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [63:0] wdata;
        int          dhi;
        int          dlo;
        logic [31:0] rhi;
        logic [31:0] rlo;
        logic [63:0] rd;
        bit          err;
        int          lat;
        bit          hold;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave answers d cycles after its strobe (d=0: same cycle); the strobe
    // cycle is wait cycle 1, so the answer is in time when d < TO.
    function automatic void ref_model(
        input bit we, input int dhi, input int dlo,
        input logic [31:0] rhi, input logic [31:0] rlo,
        output logic [63:0] rd, output bit err,
        output int lat, output int lo_cyc);
        bit hi_ok, lo_ok;
        hi_ok  = dhi < TO;
        lo_ok  = dlo < TO;
        lo_cyc = hi_ok ? dhi + 2 : -1;
        if (!hi_ok) begin
            lat = 1 + TO;
            err = 1'b1;
        end else begin
            lat = lo_cyc + (lo_ok ? dlo + 1 : TO);
            err = !lo_ok;
        end
        rd = '0;
        if (!we && hi_ok)          rd[63:32] = rhi;
        if (!we && hi_ok && lo_ok) rd[31:0]  = rlo;
    endfunction

    // Entered at the negedge of cycle 0; returns at the negedge of rsp+1.
    task automatic run_txn(
        input bit we, input logic [4:0] addr, input logic [63:0] wdata,
        input int dhi, input int dlo,
        input logic [31:0] rhi, input logic [31:0] rlo,
        input logic [63:0] exp_rd, input bit exp_err, input int exp_lat,
        input bit stray, input bit hold);
        logic [63:0] mrd, got_rd, exp_d;
        logic [5:0]  exp_a;
        logic        got_err;
        bit          merr;
        int          mlat, lo_cyc, exp_c, dly;
        int          nstb = 0, sc = 0, ph = 0, rsp_cyc = -1;
        int          ready_bad = 0, stb_bad = 0;
        ref_model(we, dhi, dlo, rhi, rlo, mrd, merr, mlat, lo_cyc);
        got_rd  = 'x;
        got_err = 1'bx;
        if (req_ready !== 1'b1) ready_bad++;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int c = 1; c <= 40 && rsp_cyc < 0; c++) begin
            @(negedge Clk);
            req_valid = hold;
            req_we    = 1'($urandom);
            req_addr  = 5'($urandom);
            req_wdata = {$urandom, $urandom};
            VMERdDone = 1'b0;
            VMEWrDone = 1'b0;
            VMERdData = $urandom;
            if (req_ready !== 1'b0) ready_bad++;
            if (VMERdMem || VMEWrMem) begin
                exp_c = (nstb == 0) ? 1 : lo_cyc;
                exp_a = {addr, (nstb != 0)};
                exp_d = (nstb == 0) ? {32'h0, wdata[63:32]}
                                    : {32'h0, wdata[31:0]};
                if (VMEWrMem !== we || VMERdMem !== !we || c != exp_c ||
                    VMEAddr !== exp_a ||
                    (we && {32'h0, VMEWrData} !== exp_d))
                    stb_bad++;
                sc = c;
                ph = nstb;
                nstb++;
            end
            dly = (ph == 0) ? dhi : dlo;
            if (nstb > 0 && c == sc + dly) begin
                if (we) VMEWrDone = 1'b1;
                else begin
                    VMERdDone = 1'b1;
                    VMERdData = (ph == 0) ? rhi : rlo;
                end
            end
            if (stray) begin
                if (we) VMERdDone = 1'($urandom);
                else    VMEWrDone = 1'($urandom);
            end
            if (rsp_valid) begin
                rsp_cyc = c;
                got_rd  = rsp_rdata;
                got_err = rsp_err;
            end
        end
        chk("latency", rsp_cyc, exp_lat);
        chk("rsp_rdata", got_rd, exp_rd);
        chk("rsp_err", {63'h0, got_err}, {63'h0, exp_err});
        chk("strobe count", nstb, (lo_cyc > 0) ? 2 : 1);
        chk("strobe fields", stb_bad, 0);
        chk("req_ready busy", ready_bad, 0);
        @(negedge Clk);
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
        req_valid = 1'b0;
        chk("rsp_valid pulse", {63'h0, rsp_valid}, 64'h0);
        chk("rsp_rdata hold", rsp_rdata, exp_rd);
    endtask

    task automatic idle_watch(input string nm, input int n, input bit inj,
                              input logic [63:0] exp_rd);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            VMERdDone = inj && (i == 0);
            VMEWrDone = inj && (i == 1);
            VMERdData = 32'hFFFF_FFFF;
            @(negedge Clk);
            if (VMERdMem || VMEWrMem || rsp_valid || !req_ready) bad++;
        end
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
        chk({nm, " idle outputs"}, bad, 0);
        chk({nm, " idle rdata"}, rsp_rdata, exp_rd);
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 7);
        return (r < 6) ? r : 255;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wd, mrd;
        logic [31:0] rh, rl;
        logic [4:0]  ad;
        bit          we, merr;
        int          dh, dl, mlat, loc;

        tbl[0] = '{1'b1, 5'h05, 64'h1122334455667788, 1, 1,
                   32'h0, 32'h0, 64'h0, 1'b0, 5, 1'b0};
        tbl[1] = '{1'b0, 5'h05, 64'h0, 1, 1, 32'hDEADBEEF, 32'h01234567,
                   64'hDEADBEEF01234567, 1'b0, 5, 1'b1};
        tbl[2] = '{1'b0, 5'h1F, 64'h0, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A,
                   64'hA5A5A5A55A5A5A5A, 1'b0, 3, 1'b0};
        tbl[3] = '{1'b0, 5'h07, 64'h0, 3, 3, 32'h0BADF00D, 32'hFEEDFACE,
                   64'h0BADF00DFEEDFACE, 1'b0, 9, 1'b0};
        tbl[4] = '{1'b0, 5'h07, 64'h0, 3, 4, 32'h12345678, 32'h9ABCDEF0,
                   64'h1234567800000000, 1'b1, 9, 1'b0};
        tbl[5] = '{1'b1, 5'h00, 64'hAAAA5555CCCC3333, 3, 3,
                   32'h0, 32'h0, 64'h0, 1'b0, 9, 1'b1};
        tbl[6] = '{1'b1, 5'h1E, 64'h0102030405060708, 255, 0,
                   32'h0, 32'h0, 64'h0, 1'b1, 5, 1'b0};
        tbl[7] = '{1'b1, 5'h11, 64'hF0F0F0F00F0F0F0F, 0, 2,
                   32'h0, 32'h0, 64'h0, 1'b0, 5, 1'b0};
        tbl[8] = '{1'b0, 5'h03, 64'h0, 255, 0, 32'h11111111, 32'h22222222,
                   64'h0, 1'b1, 5, 1'b0};

        Rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset req_ready", {63'h0, req_ready}, 64'h1);
        chk("reset rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset rsp_err", {63'h0, rsp_err}, 64'h0);
        chk("reset rsp_rdata", rsp_rdata, 64'h0);
        chk("reset VMEAddr", {58'h0, VMEAddr}, 64'h0);
        chk("reset VMEWrData", {32'h0, VMEWrData}, 64'h0);
        chk("reset strobes", {62'h0, VMERdMem, VMEWrMem}, 64'h0);
        Rst = 1'b0;
        idle_watch("after reset", 10, 1'b1, 64'h0);

        for (int i = 0; i < 9; i++)
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dhi,
                    tbl[i].dlo, tbl[i].rhi, tbl[i].rlo, tbl[i].rd,
                    tbl[i].err, tbl[i].lat, 1'b0, tbl[i].hold);

        // Entry 8 timed out on a read: a late Done must be ignored.
        idle_watch("late done", 5, 1'b1, 64'h0);

        // Reset during WAIT_LO of a write.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h12;
        req_wdata = 64'hCAFEBABE8BADF00D;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        VMEWrDone = 1'b1;
        @(negedge Clk);
        VMEWrDone = 1'b0;
        chk("rst seq lo strobe", {63'h0, VMEWrMem}, 64'h1);
        chk("rst seq lo addr", {58'h0, VMEAddr}, 64'h25);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rst seq req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst seq strobes", {62'h0, VMERdMem, VMEWrMem}, 64'h0);
        chk("rst seq VMEAddr", {58'h0, VMEAddr}, 64'h0);
        chk("rst seq rsp_valid", {63'h0, rsp_valid}, 64'h0);
        idle_watch("post reset", 6, 1'b1, 64'h0);
        run_txn(1'b0, 5'h09, 64'h0, 1, 1, 32'h13579BDF, 32'h2468ACE0,
                64'h13579BDF2468ACE0, 1'b0, 5, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom);
            ad = 5'($urandom);
            wd = {$urandom, $urandom};
            rh = $urandom;
            rl = $urandom;
            dh = pick_delay();
            dl = pick_delay();
            ref_model(we, dh, dl, rh, rl, mrd, merr, mlat, loc);
            run_txn(we, ad, wd, dh, dl, rh, rl, mrd, merr, mlat,
                    1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
